// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory port, decode handshake and redirect.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries; clear wins over push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: registered PC, single-outstanding imem request, prefetch FIFO.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  state_t        state;
  logic          req_q;
  logic [31:0]   fetch_pc, req_addr;
  logic          push, pop, full, empty, room;
  logic [CW-1:0] count, count_after;
  fetch_entry_t  head;

  assign push        = (state == ST_REQ) & bus.imem_ack & ~bus.redirect;
  assign pop         = ~empty & bus.inst_ready & ~bus.redirect;
  assign count_after = count + CW'(push) - CW'(pop);
  assign room        = count_after < CW'(DEPTH);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (bus.redirect),
    .din   ('{pc: req_addr, instr: bus.imem_rdata}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = req_addr;
  assign bus.inst_valid = ~empty;
  assign bus.inst_data  = head.instr;
  assign bus.inst_pc    = head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            req_addr <= bus.redirect_pc;
            state    <= ST_REQ;
            req_q    <= 1'b1;
          end else if (!full) begin
            req_addr <= fetch_pc;
            state    <= ST_REQ;
            req_q    <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            // an ack coinciding with the redirect closes the old request here
            if (bus.imem_ack) req_addr <= bus.redirect_pc;
            else              state    <= ST_KILL;
          end else if (bus.imem_ack) begin
            fetch_pc <= req_addr + 32'd1;
            if (room) begin
              req_addr <= req_addr + 32'd1;
            end else begin
              state <= ST_IDLE;
              req_q <= 1'b0;
            end
          end
        end
        ST_KILL: begin
          // hold the stale address until memory finishes, then restart
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            if (bus.imem_ack) begin
              req_addr <= bus.redirect_pc;
              state    <= ST_REQ;
            end
          end else if (bus.imem_ack) begin
            req_addr <= fetch_pc;
            state    <= ST_REQ;
          end
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus kill/async-reset sequences.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  logic mem_auto, man_ack;
  logic mon_en;
  int   checks = 0, failures = 0, bad5 = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus.imem_ack   = mem_auto | man_ack;
  assign bus.imem_rdata = word_of(bus.imem_addr);

  always @(negedge clk)
    if (mon_en && bus.inst_valid && bus.inst_pc == 32'd5) bad5++;

  typedef struct {
    logic        rst, ready, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 31;
  vec_t vec [NV];

  function automatic vec_t mk(input logic rst, ready, redir, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rst = rst; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d act=%h exp=%h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int idx, input logic req, input logic [31:0] addr,
                         input logic valid, input logic [31:0] pc);
    chk({tag, "_req"}, idx, 32'(bus.imem_req), 32'(req));
    if (req) chk({tag, "_addr"}, idx, bus.imem_addr, addr);
    chk({tag, "_valid"}, idx, 32'(bus.inst_valid), 32'(valid));
    if (valid) begin
      chk({tag, "_pc"}, idx, bus.inst_pc, pc);
      chk({tag, "_data"}, idx, bus.inst_data, word_of(pc));
    end
  endtask

  initial begin
    reset = 1'b1; mem_auto = 1'b1; man_ack = 1'b0; mon_en = 1'b0;
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

    // streaming with ack always high
    vec[0]  = mk(1,1,0,0,            0,0,0,0);
    vec[1]  = mk(0,1,0,0,            1,0,0,0);
    vec[2]  = mk(0,1,0,0,            1,1,1,0);
    vec[3]  = mk(0,1,0,0,            1,2,1,1);
    vec[4]  = mk(0,1,0,0,            1,3,1,2);
    vec[5]  = mk(0,1,0,0,            1,4,1,3);
    // decode stalled: two words buffered, request stops, head holds
    vec[6]  = mk(1,0,0,0,            0,0,0,0);
    vec[7]  = mk(0,0,0,0,            1,0,0,0);
    vec[8]  = mk(0,0,0,0,            1,1,1,0);
    for (int i = 9; i <= 17; i++)
      vec[i] = mk(0,0,0,0,           0,1,1,0);
    vec[18] = mk(0,1,0,0,            0,1,1,1);
    vec[19] = mk(0,1,0,0,            1,2,0,0);
    vec[20] = mk(0,1,0,0,            1,3,1,2);
    // redirect coinciding with an ack
    vec[21] = mk(0,1,1,32'h80,       1,32'h80,0,0);
    vec[22] = mk(0,1,0,0,            1,32'h81,1,32'h80);
    vec[23] = mk(0,1,0,0,            1,32'h82,1,32'h81);
    // wrap at the top of the address space
    vec[24] = mk(0,1,1,32'hFFFF_FFFF,1,32'hFFFF_FFFF,0,0);
    vec[25] = mk(0,1,0,0,            1,0,1,32'hFFFF_FFFF);
    vec[26] = mk(0,1,0,0,            1,1,1,0);
    // redirect while idle
    vec[27] = mk(0,0,0,0,            0,1,1,0);
    vec[28] = mk(0,0,0,0,            0,1,1,0);
    vec[29] = mk(0,0,1,32'h40,       1,32'h40,0,0);
    vec[30] = mk(0,0,0,0,            1,32'h41,1,32'h40);

    step();
    for (int i = 0; i < NV; i++) begin
      reset = vec[i].rst; bus.inst_ready = vec[i].ready;
      bus.redirect = vec[i].redir; bus.redirect_pc = vec[i].rpc;
      step();
      chk_out("vec", i, vec[i].req, vec[i].addr, vec[i].valid, vec[i].pc);
    end
    bus.redirect = 1'b0;

    // redirect with a request in flight: stale data must be dropped
    reset = 1'b1; mem_auto = 1'b0; man_ack = 1'b0; bus.inst_ready = 1'b1;
    step();
    reset = 1'b0; mon_en = 1'b1;
    step();                                          chk_out("kill", 1, 1, 0, 0, 0);
    bus.redirect = 1'b1; bus.redirect_pc = 32'd5; step(); chk_out("kill", 2, 1, 0, 0, 0);
    bus.redirect = 1'b0; man_ack = 1'b1;  step();    chk_out("kill", 3, 1, 5, 0, 0);
    man_ack = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
    step();                                          chk_out("kill", 4, 1, 5, 0, 0);
    bus.redirect = 1'b0; step();                     chk_out("kill", 5, 1, 5, 0, 0);
    step();                                          chk_out("kill", 6, 1, 5, 0, 0);
    man_ack = 1'b1; step();                          chk_out("kill", 7, 1, 32'h40, 0, 0);
    step();                                          chk_out("kill", 8, 1, 32'h41, 1, 32'h40);
    man_ack = 1'b0; step();                          chk_out("kill", 9, 1, 32'h41, 0, 0);
    mon_en = 1'b0;
    chk("kill_pc5_seen", 0, 32'(bad5), 32'd0);

    // asynchronous reset while a request is outstanding
    mem_auto = 1'b1;
    step(); step();
    chk_out("arst_pre", 0, 1, bus.imem_addr, 1, bus.inst_pc);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", 0, 32'(bus.imem_req), 32'd0);
    chk("arst_valid", 0, 32'(bus.inst_valid), 32'd0);
    chk("arst_addr", 0, bus.imem_addr, 32'd0);
    #1 reset = 1'b0;
    step();                                          chk_out("arst_post", 1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
